// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-point majority sampling, parity/stop checking, break
// detection and a valid/ready output FIFO carrying per-frame error flags.
module uart_rx_fifo #(
  parameter int CLK_DIV     = 1250,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic                          break_det,
  output logic                          busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int H  = CLK_DIV / 2;
  localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] C_H    = CW'(H);
  localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] I_DLAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] I_SLAST = IW'(STOP_BITS - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_err_f(input logic s, input logic [DATA_BITS-1:0] d);
    if (PARITY_TYPE == 1) return s != (^d);
    else                  return s == (^d);
  endfunction

  logic                   rx_p0, rx_p1, rx_s;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   perr, ferr, par_bit;
  logic                   smp0, smp1;
  logic [DATA_BITS-1:0]   data_sr;
  logic                   bit_v, at_mid, at_end;
  logic                   frame_done, is_brk;
  logic [DATA_BITS+1:0]   frame_word;
  logic [DATA_BITS+1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, pop, wr_en;

  // Stage p0/p1: two-flop synchroniser, idle-high out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rx_s = rx_p1;

  assign at_mid     = (cnt == C_HP1);
  assign at_end     = (cnt == C_LAST);
  assign bit_v      = maj3(smp0, smp1, rx_s);
  assign frame_done = (state == S_STOP) && at_mid && (idx == I_SLAST);
  assign is_brk     = (data_sr == '0) && (PARITY_TYPE == 0 || !par_bit) && !bit_v;
  assign frame_word = {ferr | ~bit_v, perr, data_sr};

  // Bit-level datapath: the two early samples plus the assembled character
  always_ff @(posedge clk) begin
    if (cnt == C_HM1) smp0 <= rx_s;
    if (cnt == C_H)   smp1 <= rx_s;
    if (state == S_DATA && at_mid) data_sr[idx] <= bit_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      par_bit   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= frame_done && is_brk;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
            cnt   <= CW'(1);
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        S_START: begin
          if (at_mid && bit_v) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            state <= S_DATA;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (at_end) begin
            cnt <= '0;
            if (idx == I_DLAST) begin
              idx   <= '0;
              state <= (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (at_mid) begin
            par_bit <= bit_v;
            perr    <= par_err_f(bit_v, data_sr);
          end
          if (at_end) begin
            state <= S_STOP;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          // Leave right after the last stop sample to resync on back-to-back frames
          if (frame_done) begin
            state <= is_brk ? S_BREAK : S_IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            cnt <= '0;
            idx <= idx + IW'(1);
          end else begin
            if (at_mid) ferr <= ferr | ~bit_v;
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  // Output FIFO
  assign full  = (count == DEPTH_C);
  assign pop   = m_valid && m_ready;
  assign wr_en = frame_done && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= frame_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW + 1)'(1);
      else if (!wr_en && pop) count <= count - (AW + 1)'(1);
      if (frame_done && full && !pop) overrun <= 1'b1;
      else if (ovr_clr)               overrun <= 1'b0;
    end
  end

  assign {m_frame_err, m_parity_err, m_data} = mem[rd_ptr];
  assign m_valid    = (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 16 clocks/bit, 8E1, 4-entry FIFO.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n, rx, m_ready, ovr_clr;
  logic [7:0] m_data;
  logic       m_parity_err, m_frame_err, m_valid, overrun, break_det, busy;
  logic [2:0] fifo_count;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_exp;

  uart_rx_fifo #(
    .CLK_DIV(16), .DATA_BITS(8), .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
    .overrun(overrun), .ovr_clr(ovr_clr), .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every accepted entry is checked against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected got=%h required=none", {m_frame_err, m_parity_err, m_data});
      end else begin
        mon_exp = sb.pop_front();
        if ({m_frame_err, m_parity_err, m_data} !== mon_exp) begin
          n_bad++;
          $display("FAIL sb_entry got=%h required=%h", {m_frame_err, m_parity_err, m_data}, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start, 8 data LSB first, even parity (optionally inverted), stop
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_v,
                            input logic expect_push);
    logic [10:0] bits;
    if (expect_push) sb.push_back({~stop_v, par_bad, d});
    bits = {stop_v, (^d) ^ par_bad, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (16) tick();
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; m_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({m_valid, fifo_count, overrun, break_det, busy, m_parity_err, m_frame_err, m_data} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {m_valid, fifo_count, overrun, break_det, busy, m_parity_err, m_frame_err, m_data});
    end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_latency();
    int busy_edge = 0;
    int valid_edge = 0;
    m_ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      for (int e = 1; e <= 400 && valid_edge == 0; e++) begin
        @(posedge clk); #1;
        if (busy && busy_edge == 0) busy_edge = e;
        if (m_valid) valid_edge = e;
      end
    join
    repeat (16) tick();
    n_cmp++;
    if (busy_edge !== 3) begin
      n_bad++;
      $display("FAIL busy_rise_edge got=%0d required=3", busy_edge);
    end
    n_cmp++;
    if (valid_edge !== 172) begin
      n_bad++;
      $display("FAIL valid_latency_edge got=%0d required=172", valid_edge);
    end
    n_cmp++;
    if (sb.size() !== 0 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL a5_drained got=%0d/%0d required=0/0", sb.size(), fifo_count);
    end
  endtask

  task automatic test_parity_err();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    repeat (16) tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL parity_drained got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_frame_err();
    int pulses = 0;
    fork
      begin send_frame(8'h3C, 1'b0, 1'b0, 1'b1); repeat (48) tick(); end
      for (int i = 0; i < 176 + 48; i++) begin
        @(posedge clk); #1;
        if (break_det) pulses++;
      end
    join
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL frame_err_break got=%0d required=0", pulses);
    end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() !== 0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_err_idle got=busy%b/q%0d/v%b required=0/0/0", busy, sb.size(), m_valid);
    end
  endtask

  task automatic test_glitch();
    int busy_seen = 0;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) busy_seen = 1;
    end
    n_cmp++;
    if (busy_seen !== 1) begin
      n_bad++;
      $display("FAIL glitch_busy_pulse got=%0d required=1", busy_seen);
    end
    n_cmp++;
    if (busy !== 1'b0 || fifo_count !== 3'd0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_no_entry got=busy%b/cnt%0d/v%b required=0/0/0", busy, fifo_count, m_valid);
    end
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, i <= 4);
    repeat (4) tick();
    n_cmp++;
    if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_full got=cnt%0d/ovr%b required=4/1", fifo_count, overrun);
    end
    n_cmp++;
    if (m_data !== 8'h01) begin
      n_bad++;
      $display("FAIL overrun_head got=%h required=01", m_data);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clr got=%b required=0", overrun);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 50 && (sb.size() != 0 || m_valid); i++) tick();
    n_cmp++;
    if (sb.size() !== 0 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL overrun_drain got=%0d/%0d required=0/0", sb.size(), fifo_count);
    end
  endtask

  task automatic test_break();
    int pulses = 0;
    m_ready = 1'b1;
    sb.push_back({1'b1, 1'b0, 8'h00});
    fork
      begin rx = 1'b0; repeat (640) tick(); rx = 1'b1; repeat (40) tick(); end
      for (int i = 0; i < 680; i++) begin
        @(posedge clk); #1;
        if (break_det) pulses++;
      end
    join
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL break_pulses got=%0d required=1", pulses);
    end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() !== 0) begin
      n_bad++;
      $display("FAIL break_exit got=busy%b/q%0d required=0/0", busy, sb.size());
    end
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 50 && (sb.size() != 0 || m_valid); i++) tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL after_break_7e got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    n_cmp++;
    if (fifo_count !== 3'd1) begin
      n_bad++;
      $display("FAIL pre_reset_count got=%0d required=1", fifo_count);
    end
    rx = 1'b0;
    repeat (16) tick();
    rx = 1'b1;
    repeat (40) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_data_busy got=%b required=1", busy);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({m_valid, fifo_count, overrun, break_det, busy, m_parity_err, m_frame_err, m_data} !== 17'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got=%h required=0",
               {m_valid, fifo_count, overrun, break_det, busy, m_parity_err, m_frame_err, m_data});
    end
    rst_n = 1'b1;
    repeat (4) tick();
    m_ready = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 50 && (sb.size() != 0 || m_valid); i++) tick();
    n_cmp++;
    if (sb.size() !== 0 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL post_reset_81 got=%0d/%0d required=0/0", sb.size(), fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with mid-bit majority-vote sampling, configurable data width, parity and stop bits, per-frame error flags, break detection and an output FIFO with a valid/ready read interface. It is the next-generation receive front end for board top levels. It accepts the raw RX pin and presents buffered characters to downstream logic, so one slow consumer no longer loses bytes.

## Interface

- CLK_DIV, 1250: clock cycles per bit; must be ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY_TYPE, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, ≥ 2.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous and active-low; one clock, and sampled only on the rising edge of clk.
- rx  in  1  asynchronous serial input; idle high.
- m_data  out  DATA_BITS  head-of-FIFO data.
- m_parity_err  out  1  head entry had a parity mismatch; always 0 when PARITY_TYPE=0.
- m_frame_err  out  1  head entry had a low stop bit.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head entry.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overrun  out  1  sticky; a completed frame was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.
- break_det  out  1  one-cycle pulse when a break is recognised.
- busy  out  1  receiver is not in IDLE.

## Operation

- rx passes through 2 flops, both reset to 1, to form rx_s. All decisions use rx_s.
- The bit counter runs 0..CLK_DIV-1. H = CLK_DIV/2 (integer division).
- Each bit is sampled at counts H-1, H and H+1. The bit value is the majority of the 3 samples.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rx_s=0, go to START with count=0 in that cycle (t0).
- START: if the majority at H+1 is 1, this is a false start; return to IDLE with no entry and no flags. Otherwise, at CLK_DIV-1 go to DATA.
- DATA: shift the majority value into bit index i, starting at i=0. After bit DATA_BITS-1 ends, go to PARITY if PARITY_TYPE≠0, else go to STOP.
- PARITY: store the sampled bit. parity_err = (even: sampled ≠ XOR of data; odd: sampled = XOR of data).
- STOP: a stop bit that samples 0 sets frame_err. After the H+1 sample of the last stop bit, push {frame_err, parity_err, data} in the same cycle.
  - If the frame is a break (data all 0, parity bit 0 if present, last stop bit 0), pulse break_det and go to BREAK.
  - Otherwise go to IDLE without waiting for the end of the stop bit, so the receiver can resynchronise on back-to-back frames.
- With STOP_BITS=2, frame_err is set if either stop bit samples 0.
- BREAK: wait for rx_s=1, then go to IDLE. No further frames or pulses are produced during the break.
- FIFO push and pop:
  - Push when a frame completes. Pop when m_valid & m_ready.
  - Push while full with no pop in the same cycle: the frame is dropped and overrun is set. Existing contents are unchanged.
  - Push while full with a pop in the same cycle: both are accepted and the count is unchanged.
  - Pop while empty: ignored.
  - If ovr_clr and a new overrun occur in the same cycle, overrun stays set.
- m_data, m_parity_err and m_frame_err reflect the head entry combinationally from FIFO storage. They are undefined-but-stable while m_valid=0.

## Timing

- Reset values: m_valid=0, fifo_count=0, overrun=0, break_det=0, busy=0, m_data=0, m_parity_err=0, m_frame_err=0. FSM is in IDLE and the pointers are 0.
- rx to rx_s latency: 2 cycles.
- busy rises the cycle after t0.
- N = 1 + DATA_BITS + (PARITY_TYPE≠0) + STOP_BITS.
- The push edge is at t0 + (N-1)·CLK_DIV + H + 1. m_valid and fifo_count update on the next cycle.
- A pop at cycle c: the next entry appears at c+1.
- Reset asserted mid-frame: the partial frame is discarded and the FIFO is emptied at the next clock edge.

## Test plan

Settings for all scenarios: CLK_DIV=16, DATA_BITS=8, PARITY_TYPE=1, STOP_BITS=1, FIFO_DEPTH=4.

- Send 0xA5 with parity bit 0 and stop bit 1, m_ready=1 → m_valid rises at t0+170. m_data=0xA5, both error flags 0.
- Send 0x5A with parity bit 1 (wrong) → entry 0x5A, m_parity_err=1, m_frame_err=0.
- Send 0x3C with stop bit 0 → entry 0x3C, m_frame_err=1, no break_det.
- Drive a 4-cycle low glitch on rx → busy pulses, then returns to 0. No entry is created.
- Send 0x01..0x05 with m_ready=0 → fifo_count=4 and overrun=1. Reads return 0x01..0x04. ovr_clr clears overrun.
- Hold rx low for 40 bit times → one entry with data 0x00 and m_frame_err=1, one break_det pulse. After rx returns high, a subsequent 0x7E is received correctly.
- Assert rst_n=0 mid-DATA → all outputs return to their reset values. The next frame, 0x81, is received cleanly.
